simmem_req_limiter: RTL and testbench

SIMMEM_REQ_LIMITER -- requirements
Module: simmem_req_limiter

---
 rtl/simmem_pkg.sv | 38 +++
 rtl/simmem_id_cnt_bank.sv | 92 +++++++++
 rtl/simmem_req_limiter.sv | 96 +++++++++
 tb/tb_simmem_req_limiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared types and ID-space constants for the simulated memory request path.
// Limit parameters are deliberately kept on the modules, not here.
package simmem_pkg;

  localparam int unsigned NumIds = 8;
  localparam int unsigned IdW    = $clog2(NumIds);
  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } raddr_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } waddr_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } rdata_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } wrsp_t;

endpackage

// File: rtl/simmem_id_cnt_bank.sv
// Per-ID outstanding-burst counters plus a channel total, with an admission check
// for one queried ID and a sticky flag for completions that arrive with nothing outstanding.
module simmem_id_cnt_bank
  import simmem_pkg::*;
#(
  parameter int unsigned MaxPerId = 4,
  parameter int unsigned MaxTotal = 8,
  localparam int unsigned CntW    = $clog2(MaxPerId + 1),
  localparam int unsigned TotW    = $clog2(MaxTotal + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IdW-1:0]  query_id_i,
  output logic            allow_o,
  input  logic            inc_i,
  input  logic [IdW-1:0]  inc_id_i,
  input  logic            dec_i,
  input  logic [IdW-1:0]  dec_id_i,
  output logic [TotW-1:0] total_o,
  output logic            err_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxPerId);
  localparam logic [TotW-1:0] MaxTot = TotW'(MaxTotal);

  logic [CntW-1:0] cnt_q [NumIds];
  logic [CntW-1:0] cnt_d [NumIds];
  logic [TotW-1:0] total_q, total_d;
  logic            err_q, err_d;

  logic [NumIds-1:0] up_vec;
  logic [NumIds-1:0] dn_vec;
  logic              dec_hit;
  logic              underflow;

  // Admission looks only at registered state, so completions free a slot one cycle later.
  assign allow_o = (cnt_q[query_id_i] < MaxCnt) && (total_q < MaxTot);
  assign total_o = total_q;
  assign err_o   = err_q;

  assign dec_hit   = dec_i && (cnt_q[dec_id_i] != '0);
  assign underflow = dec_i && (cnt_q[dec_id_i] == '0);

  always_comb begin
    up_vec = '0;
    dn_vec = '0;
    for (int i = 0; i < int'(NumIds); i++) begin
      up_vec[i] = inc_i && (inc_id_i == IdW'(i));
      dn_vec[i] = dec_hit && (dec_id_i == IdW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NumIds); i++) begin
      cnt_d[i] = cnt_q[i];
      if (up_vec[i] && !dn_vec[i] && (cnt_q[i] != MaxCnt)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dn_vec[i] && !up_vec[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // An underflowing completion never reaches the total, so it can not wrap.
  always_comb begin
    total_d = total_q;
    if (inc_i && !dec_hit && (total_q != MaxTot)) begin
      total_d = total_q + 1'b1;
    end else if (dec_hit && !inc_i) begin
      total_d = total_q - 1'b1;
    end
  end

  assign err_d = err_q | underflow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumIds); i++) begin
        cnt_q[i] <= '0;
      end
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NumIds); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/simmem_req_limiter.sv
// Throttles read/write address issue by outstanding bursts per ID and in total.
// Completions are observed passively on the requester-side response channels.
module simmem_req_limiter
  import simmem_pkg::*;
#(
  parameter int unsigned MaxRdPerId = 4,
  parameter int unsigned MaxWrPerId = 4,
  parameter int unsigned MaxRdTotal = 8,
  parameter int unsigned MaxWrTotal = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  input  logic                              raddr_in_valid_i,
  output logic                              raddr_in_ready_o,
  input  raddr_t                            raddr_i,
  output raddr_t                            raddr_o,
  output logic                              raddr_out_valid_o,
  input  logic                              raddr_out_ready_i,

  input  logic                              waddr_in_valid_i,
  output logic                              waddr_in_ready_o,
  input  waddr_t                            waddr_i,
  output waddr_t                            waddr_o,
  output logic                              waddr_out_valid_o,
  input  logic                              waddr_out_ready_i,

  input  logic                              rdata_valid_i,
  input  logic                              rdata_ready_i,
  input  rdata_t                            rdata_i,

  input  logic                              wrsp_valid_i,
  input  logic                              wrsp_ready_i,
  input  wrsp_t                             wrsp_i,

  output logic [$clog2(MaxRdTotal+1)-1:0]   rd_total_o,
  output logic [$clog2(MaxWrTotal+1)-1:0]   wr_total_o,
  output logic                              err_o
);

  logic rd_allow, wr_allow;
  logic rd_issue, wr_issue;
  logic rd_done, wr_done;
  logic rd_err, wr_err;

  // Payload and response fields beyond id/last are not needed for counting.
  logic unused_rsp;
  assign unused_rsp = ^{rdata_i.data, rdata_i.resp, wrsp_i.resp};

  assign raddr_o           = raddr_i;
  assign raddr_out_valid_o = raddr_in_valid_i & rd_allow;
  assign raddr_in_ready_o  = raddr_out_ready_i & rd_allow;
  assign rd_issue          = raddr_out_valid_o & raddr_out_ready_i;
  assign rd_done           = rdata_valid_i & rdata_ready_i & rdata_i.last;

  assign waddr_o           = waddr_i;
  assign waddr_out_valid_o = waddr_in_valid_i & wr_allow;
  assign waddr_in_ready_o  = waddr_out_ready_i & wr_allow;
  assign wr_issue          = waddr_out_valid_o & waddr_out_ready_i;
  assign wr_done           = wrsp_valid_i & wrsp_ready_i;

  assign err_o = rd_err | wr_err;

  simmem_id_cnt_bank #(
    .MaxPerId (MaxRdPerId),
    .MaxTotal (MaxRdTotal)
  ) u_rd_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .query_id_i (raddr_i.id),
    .allow_o    (rd_allow),
    .inc_i      (rd_issue),
    .inc_id_i   (raddr_i.id),
    .dec_i      (rd_done),
    .dec_id_i   (rdata_i.id),
    .total_o    (rd_total_o),
    .err_o      (rd_err)
  );

  simmem_id_cnt_bank #(
    .MaxPerId (MaxWrPerId),
    .MaxTotal (MaxWrTotal)
  ) u_wr_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .query_id_i (waddr_i.id),
    .allow_o    (wr_allow),
    .inc_i      (wr_issue),
    .inc_id_i   (waddr_i.id),
    .dec_i      (wr_done),
    .dec_id_i   (wrsp_i.id),
    .total_o    (wr_total_o),
    .err_o      (wr_err)
  );

endmodule

// File: tb/tb_simmem_req_limiter.sv
// Bench for simmem_req_limiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against an outstanding-count model.
module tb_simmem_req_limiter;
  import simmem_pkg::*;

  localparam int MaxPer = 4;
  localparam int MaxTot = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst;
  logic   raddr_in_valid, raddr_in_ready, raddr_out_valid, raddr_out_ready;
  raddr_t raddr_in, raddr_out;
  logic   waddr_in_valid, waddr_in_ready, waddr_out_valid, waddr_out_ready;
  waddr_t waddr_in, waddr_out;
  logic   rdata_valid, rdata_ready;
  rdata_t rdata;
  logic   wrsp_valid, wrsp_ready;
  wrsp_t  wrsp;
  logic [3:0] rd_total, wr_total;
  logic   err;

  simmem_req_limiter #(
    .MaxRdPerId (MaxPer),
    .MaxWrPerId (MaxPer),
    .MaxRdTotal (MaxTot),
    .MaxWrTotal (MaxTot)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .raddr_in_valid_i  (raddr_in_valid),
    .raddr_in_ready_o  (raddr_in_ready),
    .raddr_i           (raddr_in),
    .raddr_o           (raddr_out),
    .raddr_out_valid_o (raddr_out_valid),
    .raddr_out_ready_i (raddr_out_ready),
    .waddr_in_valid_i  (waddr_in_valid),
    .waddr_in_ready_o  (waddr_in_ready),
    .waddr_i           (waddr_in),
    .waddr_o           (waddr_out),
    .waddr_out_valid_o (waddr_out_valid),
    .waddr_out_ready_i (waddr_out_ready),
    .rdata_valid_i     (rdata_valid),
    .rdata_ready_i     (rdata_ready),
    .rdata_i           (rdata),
    .wrsp_valid_i      (wrsp_valid),
    .wrsp_ready_i      (wrsp_ready),
    .wrsp_i            (wrsp),
    .rd_total_o        (rd_total),
    .wr_total_o        (wr_total),
    .err_o             (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: outstanding bursts per ID and in total, plus sticky error.
  int rcnt[NumIds];
  int wcnt[NumIds];
  int rtot, wtot;
  bit merr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rd_ok();
    return (rcnt[raddr_in.id] < MaxPer) && (rtot < MaxTot);
  endfunction

  function automatic bit wr_ok();
    return (wcnt[waddr_in.id] < MaxPer) && (wtot < MaxTot);
  endfunction

  task automatic begin_cycle();
    @(negedge clk);
    rst             = 1'b0;
    raddr_in_valid  = 1'b0;
    raddr_out_ready = 1'b0;
    raddr_in.id     = '0;
    raddr_in.addr   = $urandom();
    raddr_in.len    = 8'($urandom());
    raddr_in.size   = 3'($urandom());
    raddr_in.burst  = 2'($urandom());
    waddr_in_valid  = 1'b0;
    waddr_out_ready = 1'b0;
    waddr_in.id     = '0;
    waddr_in.addr   = $urandom();
    waddr_in.len    = 8'($urandom());
    waddr_in.size   = 3'($urandom());
    waddr_in.burst  = 2'($urandom());
    rdata_valid     = 1'b0;
    rdata_ready     = 1'b0;
    rdata.id        = '0;
    rdata.data      = $urandom();
    rdata.resp      = 2'($urandom());
    rdata.last      = 1'b0;
    wrsp_valid      = 1'b0;
    wrsp_ready      = 1'b0;
    wrsp.id         = '0;
    wrsp.resp       = 2'($urandom());
  endtask

  task automatic check_cycle();
    #1;
    chk("raddr_out_valid", raddr_out_valid, raddr_in_valid & rd_ok());
    chk("raddr_in_ready", raddr_in_ready, raddr_out_ready & rd_ok());
    chk("raddr_payload", raddr_out, raddr_in);
    chk("waddr_out_valid", waddr_out_valid, waddr_in_valid & wr_ok());
    chk("waddr_in_ready", waddr_in_ready, waddr_out_ready & wr_ok());
    chk("waddr_payload", waddr_out, waddr_in);
    chk("rd_total", rd_total, rtot);
    chk("wr_total", wr_total, wtot);
    chk("err", err, merr);
  endtask

  task automatic end_cycle();
    bit r_iss, w_iss, r_cmp, w_cmp, r_cok, w_cok;
    if (rst) begin
      for (int i = 0; i < int'(NumIds); i++) begin
        rcnt[i] = 0;
        wcnt[i] = 0;
      end
      rtot = 0;
      wtot = 0;
      merr = 0;
    end else begin
      r_iss = raddr_in_valid && raddr_out_ready && rd_ok();
      w_iss = waddr_in_valid && waddr_out_ready && wr_ok();
      r_cmp = rdata_valid && rdata_ready && rdata.last;
      w_cmp = wrsp_valid && wrsp_ready;
      r_cok = r_cmp && (rcnt[rdata.id] > 0);
      w_cok = w_cmp && (wcnt[wrsp.id] > 0);
      if ((r_cmp && !r_cok) || (w_cmp && !w_cok)) merr = 1;
      if (r_iss) begin rcnt[raddr_in.id]++; rtot++; end
      if (w_iss) begin wcnt[waddr_in.id]++; wtot++; end
      if (r_cok) begin rcnt[rdata.id]--; rtot--; end
      if (w_cok) begin wcnt[wrsp.id]--; wtot--; end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    begin_cycle();
    rst = 1'b1;
    check_cycle();
    end_cycle();
  endtask

  task automatic do_read(input int id);
    begin_cycle();
    raddr_in_valid  = 1'b1;
    raddr_out_ready = 1'b1;
    raddr_in.id     = IdW'(id);
    check_cycle();
    end_cycle();
  endtask

  task automatic do_write(input int id);
    begin_cycle();
    waddr_in_valid  = 1'b1;
    waddr_out_ready = 1'b1;
    waddr_in.id     = IdW'(id);
    check_cycle();
    end_cycle();
  endtask

  // Prefer IDs with something outstanding so completions mostly land legally.
  function automatic int pick_id(input bit wr);
    int start;
    int idx;
    start = $urandom_range(0, NumIds - 1);
    for (int k = 0; k < int'(NumIds); k++) begin
      idx = (start + k) % NumIds;
      if ((wr ? wcnt[idx] : rcnt[idx]) > 0) return idx;
    end
    return start;
  endfunction

  initial begin
    for (int i = 0; i < int'(NumIds); i++) begin
      rcnt[i] = 0;
      wcnt[i] = 0;
    end
    rtot = 0;
    wtot = 0;
    merr = 0;
    rst  = 1'b1;
    // First edges: DUT state is undefined until reset has been sampled.
    begin_cycle(); rst = 1'b1; end_cycle();
    do_reset();

    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1;
    check_cycle();
    chk("reset_rd_total", rd_total, 0);
    chk("reset_wr_total", wr_total, 0);
    chk("reset_err", err, 0);
    chk("reset_rd_ready", raddr_in_ready, 1);
    rst = 1'b1;
    end_cycle();

    // Per-ID limit on ID 2, other IDs unaffected.
    for (int i = 0; i < 4; i++) do_read(2);
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd2;
    check_cycle();
    chk("id2_fifth_ready", raddr_in_ready, 0);
    chk("id2_fifth_valid", raddr_out_valid, 0);
    end_cycle();
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd3;
    check_cycle();
    chk("id3_ready", raddr_in_ready, 1);
    end_cycle();
    begin_cycle(); check_cycle();
    chk("id2_id3_total", rd_total, 5);
    end_cycle();
    do_reset();

    // Total limit and one-cycle release latency.
    for (int i = 0; i < 8; i++) do_read(i % 4);
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd4;
    check_cycle();
    chk("total_full_ready", raddr_in_ready, 0);
    end_cycle();
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd4;
    rdata_valid = 1'b1; rdata_ready = 1'b1; rdata.id = 3'd1; rdata.last = 1'b1;
    check_cycle();
    chk("release_same_cycle", raddr_in_ready, 0);
    end_cycle();
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd4;
    check_cycle();
    chk("release_next_cycle", raddr_in_ready, 1);
    end_cycle();
    begin_cycle(); check_cycle();
    chk("refill_total", rd_total, 8);
    end_cycle();
    do_reset();

    // Simultaneous issue and completion on ID 5 with two outstanding.
    do_read(5);
    do_read(5);
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd5;
    rdata_valid = 1'b1; rdata_ready = 1'b1; rdata.id = 3'd5; rdata.last = 1'b1;
    check_cycle();
    end_cycle();
    begin_cycle(); check_cycle();
    chk("same_id_total", rd_total, 2);
    end_cycle();
    do_read(5);
    do_read(5);
    begin_cycle();
    raddr_in_valid = 1'b1; raddr_out_ready = 1'b1; raddr_in.id = 3'd5;
    check_cycle();
    chk("id5_full_after_two", raddr_in_ready, 0);
    end_cycle();

    // Non-last beats do not release.
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      rdata_valid = 1'b1; rdata_ready = 1'b1; rdata.id = 3'd5; rdata.last = 1'b0;
      check_cycle();
      end_cycle();
    end
    begin_cycle(); check_cycle();
    chk("nonlast_total", rd_total, 4);
    end_cycle();
    begin_cycle();
    rdata_valid = 1'b1; rdata_ready = 1'b1; rdata.id = 3'd5; rdata.last = 1'b1;
    check_cycle();
    end_cycle();
    begin_cycle(); check_cycle();
    chk("last_total", rd_total, 3);
    end_cycle();

    // Write response with nothing outstanding.
    begin_cycle();
    wrsp_valid = 1'b1; wrsp_ready = 1'b1; wrsp.id = 3'd7;
    check_cycle();
    chk("err_before", err, 0);
    end_cycle();
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); check_cycle();
      chk("err_sticky", err, 1);
      chk("err_wr_total", wr_total, 0);
      chk("err_rd_total", rd_total, 3);
      end_cycle();
    end

    // Reset with writes outstanding, and a handshake during reset ignored.
    for (int i = 0; i < 3; i++) do_write(1);
    begin_cycle(); check_cycle();
    chk("pre_reset_wr_total", wr_total, 3);
    end_cycle();
    begin_cycle();
    rst = 1'b1;
    waddr_in_valid = 1'b1; waddr_out_ready = 1'b1; waddr_in.id = 3'd1;
    check_cycle();
    end_cycle();
    begin_cycle(); check_cycle();
    chk("post_reset_wr_total", wr_total, 0);
    chk("post_reset_err", err, 0);
    end_cycle();
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      waddr_in_valid = 1'b1; waddr_out_ready = 1'b1; waddr_in.id = 3'd6;
      check_cycle();
      chk("post_reset_wr_accept", waddr_in_ready, 1);
      end_cycle();
    end
    begin_cycle();
    waddr_in_valid = 1'b1; waddr_out_ready = 1'b1; waddr_in.id = 3'd6;
    check_cycle();
    chk("post_reset_wr_block", waddr_in_ready, 0);
    end_cycle();
    do_reset();

    // Randomized traffic on both channels.
    for (int c = 0; c < 2000; c++) begin
      begin_cycle();
      rst             = ($urandom_range(0, 299) == 0);
      raddr_in_valid  = ($urandom_range(0, 3) != 0);
      raddr_out_ready = ($urandom_range(0, 3) != 0);
      raddr_in.id     = IdW'($urandom_range(0, NumIds - 1));
      waddr_in_valid  = ($urandom_range(0, 3) != 0);
      waddr_out_ready = ($urandom_range(0, 3) != 0);
      waddr_in.id     = IdW'($urandom_range(0, NumIds - 1));
      rdata_valid     = ($urandom_range(0, 1) != 0);
      rdata_ready     = ($urandom_range(0, 3) != 0);
      rdata.last      = ($urandom_range(0, 1) != 0);
      rdata.id        = IdW'(($urandom_range(0, 15) == 0) ?
                             $urandom_range(0, NumIds - 1) : pick_id(1'b0));
      wrsp_valid      = ($urandom_range(0, 2) == 0);
      wrsp_ready      = ($urandom_range(0, 3) != 0);
      wrsp.id         = IdW'(($urandom_range(0, 15) == 0) ?
                            $urandom_range(0, NumIds - 1) : pick_id(1'b1));
      check_cycle();
      end_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
